// File: rtl/rs_age_ordered.sv
`default_nettype none
// ============================================================================
//  Module      : rs_age_ordered
//  Description : Reservation station with CDB operand wakeup and oldest-ready
//                issue selected through a pairwise age matrix.
//  Revision    : 1.0 - initial release
// ============================================================================
module rs_age_ordered #(
    parameter int DEPTH  = 16,
    parameter int XLEN   = 32,
    parameter int TAG_W  = 4,
    parameter int NCDB   = 3,
    parameter int OP_W   = 6,
    parameter int IMM_W  = 32,
    parameter int ADDR_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [OP_W-1:0]            in_op,
    input  logic [ADDR_W-1:0]          in_pc,
    input  logic [IMM_W-1:0]           in_imm,
    input  logic [TAG_W-1:0]           in_rd_tag,
    input  logic                       in_q1_wait,
    input  logic [TAG_W-1:0]           in_q1,
    input  logic [XLEN-1:0]            in_v1,
    input  logic                       in_q2_wait,
    input  logic [TAG_W-1:0]           in_q2,
    input  logic [XLEN-1:0]            in_v2,
    input  logic [NCDB-1:0]            cdb_valid,
    input  logic [NCDB*TAG_W-1:0]      cdb_tag,
    input  logic [NCDB*XLEN-1:0]       cdb_value,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OP_W-1:0]            out_op,
    output logic [ADDR_W-1:0]          out_pc,
    output logic [IMM_W-1:0]           out_imm,
    output logic [TAG_W-1:0]           out_rd_tag,
    output logic [XLEN-1:0]            out_v1,
    output logic [XLEN-1:0]            out_v2,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_IDX_W = $clog2(DEPTH);

    // Entry storage
    logic              r_valid [DEPTH];
    logic [OP_W-1:0]   r_op    [DEPTH];
    logic [ADDR_W-1:0] r_pc    [DEPTH];
    logic [IMM_W-1:0]  r_imm   [DEPTH];
    logic [TAG_W-1:0]  r_rd    [DEPTH];
    logic              r_q1w   [DEPTH];
    logic [TAG_W-1:0]  r_q1    [DEPTH];
    logic [XLEN-1:0]   r_v1    [DEPTH];
    logic              r_q2w   [DEPTH];
    logic [TAG_W-1:0]  r_q2    [DEPTH];
    logic [XLEN-1:0]   r_v2    [DEPTH];
    // r_older[j][i] = 1 when entry j was inserted before entry i
    logic [DEPTH-1:0]  r_older [DEPTH];

    logic [c_CNT_W-1:0] r_count;
    logic               r_out_valid;
    logic [OP_W-1:0]    r_out_op;
    logic [ADDR_W-1:0]  r_out_pc;
    logic [IMM_W-1:0]   r_out_imm;
    logic [TAG_W-1:0]   r_out_rd;
    logic [XLEN-1:0]    r_out_v1;
    logic [XLEN-1:0]    r_out_v2;

    logic [DEPTH-1:0]   w_valid;
    logic [DEPTH-1:0]   w_rdy;
    logic [DEPTH-1:0]   w_cand;
    logic [c_IDX_W-1:0] w_free_idx;
    logic [c_IDX_W-1:0] w_sel_idx;
    logic               w_insert;
    logic               w_can_issue;
    logic               w_issue;
    logic               w_in_q1w;
    logic               w_in_q2w;
    logic [XLEN-1:0]    w_in_v1;
    logic [XLEN-1:0]    w_in_v2;

    assign in_ready    = (r_count != c_CNT_W'(DEPTH));
    assign w_insert    = rdy && in_valid && in_ready;
    assign w_can_issue = !r_out_valid || out_ready;
    assign w_issue     = rdy && w_can_issue && (|w_rdy);

    // Same-cycle bypass for the incoming instruction; lowest channel wins
    always_comb begin
        w_in_q1w = in_q1_wait;
        w_in_v1  = in_v1;
        w_in_q2w = in_q2_wait;
        w_in_v2  = in_v2;
        for (int c = NCDB - 1; c >= 0; c--) begin
            if (in_q1_wait && cdb_valid[c] && (cdb_tag[c*TAG_W +: TAG_W] == in_q1)) begin
                w_in_q1w = 1'b0;
                w_in_v1  = cdb_value[c*XLEN +: XLEN];
            end
            if (in_q2_wait && cdb_valid[c] && (cdb_tag[c*TAG_W +: TAG_W] == in_q2)) begin
                w_in_q2w = 1'b0;
                w_in_v2  = cdb_value[c*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        w_free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!w_valid[i]) begin
                w_free_idx = c_IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_sel_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_sel_idx = c_IDX_W'(i);
            end
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic             w_ins_here;
        logic             w_iss_here;
        logic             w_q1w_nx;
        logic             w_q2w_nx;
        logic [XLEN-1:0]  w_v1_nx;
        logic [XLEN-1:0]  w_v2_nx;
        logic [DEPTH-1:0] w_col;

        assign w_valid[gi] = r_valid[gi];
        assign w_rdy[gi]   = r_valid[gi] && !r_q1w[gi] && !r_q2w[gi];
        assign w_ins_here  = w_insert && (w_free_idx == c_IDX_W'(gi));
        assign w_iss_here  = w_issue && (w_sel_idx == c_IDX_W'(gi));

        // A ready entry is a candidate only if no older entry is also ready
        always_comb begin
            w_col = '0;
            for (int j = 0; j < DEPTH; j++) begin
                w_col[j] = r_older[j][gi];
            end
        end
        assign w_cand[gi] = w_rdy[gi] && !(|(w_rdy & w_col));

        always_comb begin
            w_q1w_nx = r_q1w[gi];
            w_v1_nx  = r_v1[gi];
            w_q2w_nx = r_q2w[gi];
            w_v2_nx  = r_v2[gi];
            for (int c = NCDB - 1; c >= 0; c--) begin
                if (r_valid[gi] && r_q1w[gi] && cdb_valid[c] &&
                    (cdb_tag[c*TAG_W +: TAG_W] == r_q1[gi])) begin
                    w_q1w_nx = 1'b0;
                    w_v1_nx  = cdb_value[c*XLEN +: XLEN];
                end
                if (r_valid[gi] && r_q2w[gi] && cdb_valid[c] &&
                    (cdb_tag[c*TAG_W +: TAG_W] == r_q2[gi])) begin
                    w_q2w_nx = 1'b0;
                    w_v2_nx  = cdb_value[c*XLEN +: XLEN];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid[gi] <= 1'b0;
                r_op[gi]    <= '0;
                r_pc[gi]    <= '0;
                r_imm[gi]   <= '0;
                r_rd[gi]    <= '0;
                r_q1w[gi]   <= 1'b0;
                r_q1[gi]    <= '0;
                r_v1[gi]    <= '0;
                r_q2w[gi]   <= 1'b0;
                r_q2[gi]    <= '0;
                r_v2[gi]    <= '0;
                r_older[gi] <= '0;
            end else if (flush) begin
                r_valid[gi] <= 1'b0;
                r_older[gi] <= '0;
            end else if (rdy) begin
                if (w_ins_here) begin
                    r_valid[gi] <= 1'b1;
                    r_op[gi]    <= in_op;
                    r_pc[gi]    <= in_pc;
                    r_imm[gi]   <= in_imm;
                    r_rd[gi]    <= in_rd_tag;
                    r_q1w[gi]   <= w_in_q1w;
                    r_q1[gi]    <= in_q1;
                    r_v1[gi]    <= w_in_v1;
                    r_q2w[gi]   <= w_in_q2w;
                    r_q2[gi]    <= in_q2;
                    r_v2[gi]    <= w_in_v2;
                end else begin
                    if (w_iss_here) begin
                        r_valid[gi] <= 1'b0;
                    end
                    r_q1w[gi] <= w_q1w_nx;
                    r_v1[gi]  <= w_v1_nx;
                    r_q2w[gi] <= w_q2w_nx;
                    r_v2[gi]  <= w_v2_nx;
                end
                // Row gi marks which entries are younger than gi
                if (w_insert) begin
                    r_older[gi][w_free_idx] <= r_valid[gi];
                end
                if (w_ins_here) begin
                    r_older[gi] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_op    <= '0;
            r_out_pc    <= '0;
            r_out_imm   <= '0;
            r_out_rd    <= '0;
            r_out_v1    <= '0;
            r_out_v2    <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (rdy && w_can_issue) begin
            r_out_valid <= w_issue;
            if (w_issue) begin
                r_out_op  <= r_op[w_sel_idx];
                r_out_pc  <= r_pc[w_sel_idx];
                r_out_imm <= r_imm[w_sel_idx];
                r_out_rd  <= r_rd[w_sel_idx];
                r_out_v1  <= r_v1[w_sel_idx];
                r_out_v2  <= r_v2[w_sel_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_count <= '0;
        end else if (rdy) begin
            r_count <= r_count + c_CNT_W'(w_insert) - c_CNT_W'(w_issue);
        end
    end

    assign out_valid  = r_out_valid;
    assign out_op     = r_out_op;
    assign out_pc     = r_out_pc;
    assign out_imm    = r_out_imm;
    assign out_rd_tag = r_out_rd;
    assign out_v1     = r_out_v1;
    assign out_v2     = r_out_v2;
    assign count      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_rs_age_ordered.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rs_age_ordered
//  Description : Directed self-checking bench for rs_age_ordered.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_age_ordered;

    localparam int DEPTH  = 16;
    localparam int XLEN   = 32;
    localparam int TAG_W  = 4;
    localparam int NCDB   = 3;
    localparam int OP_W   = 6;
    localparam int IMM_W  = 32;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  rdy;
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [OP_W-1:0]       in_op;
    logic [ADDR_W-1:0]     in_pc;
    logic [IMM_W-1:0]      in_imm;
    logic [TAG_W-1:0]      in_rd_tag;
    logic                  in_q1_wait;
    logic [TAG_W-1:0]      in_q1;
    logic [XLEN-1:0]       in_v1;
    logic                  in_q2_wait;
    logic [TAG_W-1:0]      in_q2;
    logic [XLEN-1:0]       in_v2;
    logic [NCDB-1:0]       cdb_valid;
    logic [NCDB*TAG_W-1:0] cdb_tag;
    logic [NCDB*XLEN-1:0]  cdb_value;
    logic                  out_valid;
    logic                  out_ready;
    logic [OP_W-1:0]       out_op;
    logic [ADDR_W-1:0]     out_pc;
    logic [IMM_W-1:0]      out_imm;
    logic [TAG_W-1:0]      out_rd_tag;
    logic [XLEN-1:0]       out_v1;
    logic [XLEN-1:0]       out_v2;
    logic [CNT_W-1:0]      count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rs_age_ordered #(
        .DEPTH(DEPTH), .XLEN(XLEN), .TAG_W(TAG_W), .NCDB(NCDB),
        .OP_W(OP_W), .IMM_W(IMM_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_pc(in_pc),
        .in_imm(in_imm), .in_rd_tag(in_rd_tag),
        .in_q1_wait(in_q1_wait), .in_q1(in_q1), .in_v1(in_v1),
        .in_q2_wait(in_q2_wait), .in_q2(in_q2), .in_v2(in_v2),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_pc(out_pc), .out_imm(out_imm), .out_rd_tag(out_rd_tag),
        .out_v1(out_v1), .out_v2(out_v2), .count(count)
    );

    // Advance one edge; inputs and samples both sit 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [3:0] rd,
                         input logic q1w, input logic [3:0] q1, input logic [31:0] v1,
                         input logic q2w, input logic [3:0] q2, input logic [31:0] v2);
        in_valid   = 1'b1;
        in_op      = pc[5:0];
        in_pc      = pc;
        in_imm     = ~pc;
        in_rd_tag  = rd;
        in_q1_wait = q1w;
        in_q1      = q1;
        in_v1      = v1;
        in_q2_wait = q2w;
        in_q2      = q2;
        in_v2      = v2;
    endtask

    task automatic idle_inputs();
        in_valid   = 1'b0;
        in_op      = '0;
        in_pc      = '0;
        in_imm     = '0;
        in_rd_tag  = '0;
        in_q1_wait = 1'b0;
        in_q1      = '0;
        in_v1      = '0;
        in_q2_wait = 1'b0;
        in_q2      = '0;
        in_v2      = '0;
        cdb_valid  = '0;
        cdb_tag    = '0;
        cdb_value  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; out_ready = 1'b1;
        idle_inputs();
        step(); step();
        rst = 1'b0;
        n_checks++;
        if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_checks++;
        if (out_v1 !== 32'd0 || out_rd_tag !== 4'd0) begin
            n_fail++; $display("FAIL reset_out_data: got v1=%0h tag=%0h expected 0 0", out_v1, out_rd_tag);
        end
    endtask

    task automatic test_basic();
        offer(32'h40, 4'd3, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd7);
        step();
        idle_inputs();
        n_checks++;
        if (count !== 5'd1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_after_insert: got count=%0d ov=%b expected 1 0", count, out_valid);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_v1 !== 32'd5 || out_v2 !== 32'd7 || out_rd_tag !== 4'd3) begin
            n_fail++; $display("FAIL basic_issue: got ov=%b v1=%0h v2=%0h tag=%0h expected 1 5 7 3",
                               out_valid, out_v1, out_v2, out_rd_tag);
        end
        n_checks++;
        if (count !== 5'd0) begin n_fail++; $display("FAIL basic_count: got %0d expected 0", count); end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got ov=%b expected 0", out_valid); end
    endtask

    task automatic test_order();
        offer(32'h100, 4'd1, 1'b1, 4'd2, 32'd0, 1'b0, 4'd0, 32'h3);
        step();
        offer(32'h104, 4'd2, 1'b0, 4'd0, 32'h21, 1'b0, 4'd0, 32'h22);
        step();
        idle_inputs();
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_rd_tag !== 4'd2 || count !== 5'd1) begin
            n_fail++; $display("FAIL order_b_first: got ov=%b tag=%0h count=%0d expected 1 2 1",
                               out_valid, out_rd_tag, count);
        end
        cdb_valid = 3'b010;
        cdb_tag[1*TAG_W +: TAG_W] = 4'd2;
        cdb_value[1*XLEN +: XLEN] = 32'h99;
        step();
        idle_inputs();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL order_wake_latency: got ov=%b expected 0", out_valid); end
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_rd_tag !== 4'd1 || out_v1 !== 32'h99 || out_v2 !== 32'h3) begin
            n_fail++; $display("FAIL order_a_issue: got ov=%b tag=%0h v1=%0h v2=%0h expected 1 1 99 3",
                               out_valid, out_rd_tag, out_v1, out_v2);
        end
        step();
    endtask

    task automatic test_dual_wake();
        offer(32'h200, 4'd7, 1'b1, 4'd4, 32'd0, 1'b1, 4'd5, 32'd0);
        step();
        idle_inputs();
        cdb_valid = 3'b101;
        cdb_tag[0*TAG_W +: TAG_W]  = 4'd4;
        cdb_value[0*XLEN +: XLEN]  = 32'hA4;
        cdb_tag[2*TAG_W +: TAG_W]  = 4'd5;
        cdb_value[2*XLEN +: XLEN]  = 32'hB5;
        step();
        idle_inputs();
        n_checks++;
        if (out_valid !== 1'b0 || count !== 5'd1) begin
            n_fail++; $display("FAIL dual_wake_hold: got ov=%b count=%0d expected 0 1", out_valid, count);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_v1 !== 32'hA4 || out_v2 !== 32'hB5 || out_rd_tag !== 4'd7) begin
            n_fail++; $display("FAIL dual_wake_issue: got ov=%b v1=%0h v2=%0h tag=%0h expected 1 a4 b5 7",
                               out_valid, out_v1, out_v2, out_rd_tag);
        end
        step();
    endtask

    task automatic test_bypass();
        offer(32'h300, 4'd9, 1'b1, 4'd6, 32'hDEAD, 1'b0, 4'd0, 32'h5);
        cdb_valid = 3'b011;
        cdb_tag[0*TAG_W +: TAG_W] = 4'd6;
        cdb_value[0*XLEN +: XLEN] = 32'h11;
        cdb_tag[1*TAG_W +: TAG_W] = 4'd6;
        cdb_value[1*XLEN +: XLEN] = 32'h22;
        step();
        idle_inputs();
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_v1 !== 32'h11 || out_rd_tag !== 4'd9) begin
            n_fail++; $display("FAIL bypass_issue: got ov=%b v1=%0h tag=%0h expected 1 11 9",
                               out_valid, out_v1, out_rd_tag);
        end
        step();
    endtask

    task automatic test_freeze();
        rdy = 1'b0;
        offer(32'h400, 4'd4, 1'b0, 4'd0, 32'h1, 1'b0, 4'd0, 32'h2);
        step();
        n_checks++;
        if (count !== 5'd0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL freeze_hold: got count=%0d ov=%b expected 0 0", count, out_valid);
        end
        rdy = 1'b1;
        step();
        idle_inputs();
        n_checks++;
        if (count !== 5'd1) begin n_fail++; $display("FAIL freeze_release: got count=%0d expected 1", count); end
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h400) begin
            n_fail++; $display("FAIL freeze_issue: got ov=%b pc=%0h expected 1 400", out_valid, out_pc);
        end
        step();
    endtask

    task automatic test_full_age();
        logic [31:0] exp_pc [14];
        int k;
        // Park a ready instruction in the output register and stall it
        out_ready = 1'b0;
        offer(32'h0FF0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        step();
        idle_inputs();
        step();
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 5 || i == 9 || i == 12)
                offer(32'h1000 + i, 4'(i), 1'b0, 4'd0, 32'(i), 1'b0, 4'd0, 32'h0);
            else
                offer(32'h1000 + i, 4'(i), 1'b1, 4'd15, 32'h0, 1'b0, 4'd0, 32'h0);
            step();
        end
        n_checks++;
        if (count !== 5'd16 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL full_count: got count=%0d in_ready=%b expected 16 0", count, in_ready);
        end
        offer(32'h3000, 4'd1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        step();
        idle_inputs();
        n_checks++;
        if (count !== 5'd16 || out_valid !== 1'b1 || out_pc !== 32'h0FF0) begin
            n_fail++; $display("FAIL full_reject_stall: got count=%0d ov=%b pc=%0h expected 16 1 ff0",
                               count, out_valid, out_pc);
        end
        out_ready = 1'b1;
        step();
        n_checks++;
        if (out_pc !== 32'h1005 || count !== 5'd15) begin
            n_fail++; $display("FAIL full_first_ready: got pc=%0h count=%0d expected 1005 15", out_pc, count);
        end
        step();
        n_checks++;
        if (out_pc !== 32'h1009 || count !== 5'd14) begin
            n_fail++; $display("FAIL full_second_ready: got pc=%0h count=%0d expected 1009 14", out_pc, count);
        end
        step();
        n_checks++;
        if (out_pc !== 32'h100C || out_v1 !== 32'd12) begin
            n_fail++; $display("FAIL full_third_ready: got pc=%0h v1=%0h expected 100c c", out_pc, out_v1);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0 || count !== 5'd13) begin
            n_fail++; $display("FAIL full_none_ready: got ov=%b count=%0d expected 0 13", out_valid, count);
        end
        // Youngest instruction lands in freed slot 5, below many older entries
        offer(32'h2000, 4'd2, 1'b1, 4'd15, 32'h0, 1'b0, 4'd0, 32'h0);
        step();
        idle_inputs();
        cdb_valid = 3'b100;
        cdb_tag[2*TAG_W +: TAG_W] = 4'd15;
        cdb_value[2*XLEN +: XLEN] = 32'h77;
        step();
        idle_inputs();
        k = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i != 5 && i != 9 && i != 12) begin
                exp_pc[k] = 32'h1000 + i;
                k++;
            end
        end
        exp_pc[13] = 32'h2000;
        for (int i = 0; i < 14; i++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_pc !== exp_pc[i] || out_v1 !== 32'h77) begin
                n_fail++; $display("FAIL age_order[%0d]: got ov=%b pc=%0h v1=%0h expected 1 %0h 77",
                                   i, out_valid, out_pc, out_v1, exp_pc[i]);
            end
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0 || count !== 5'd0) begin
            n_fail++; $display("FAIL age_drain: got ov=%b count=%0d expected 0 0", out_valid, count);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        offer(32'h500, 4'd8, 1'b0, 4'd0, 32'h1, 1'b0, 4'd0, 32'h2);
        step();
        for (int i = 1; i < 6; i++) begin
            offer(32'h500 + i, 4'(i), 1'b1, 4'd9, 32'h0, 1'b0, 4'd0, 32'h0);
            step();
        end
        idle_inputs();
        n_checks++;
        if (count !== 5'd5 || out_valid !== 1'b1 || out_pc !== 32'h500) begin
            n_fail++; $display("FAIL flush_setup: got count=%0d ov=%b pc=%0h expected 5 1 500",
                               count, out_valid, out_pc);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (count !== 5'd0 || out_valid !== 1'b0 || out_pc !== 32'h500) begin
            n_fail++; $display("FAIL flush_clear: got count=%0d ov=%b pc=%0h expected 0 0 500",
                               count, out_valid, out_pc);
        end
        cdb_valid = 3'b001;
        cdb_tag[0*TAG_W +: TAG_W] = 4'd9;
        cdb_value[0*XLEN +: XLEN] = 32'h55;
        step();
        idle_inputs();
        step();
        n_checks++;
        if (count !== 5'd0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_no_revive: got count=%0d ov=%b expected 0 0", count, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_order();
        test_dual_wake();
        test_bypass();
        test_freeze();
        test_full_age();
        test_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
